seq_chunk_adder: RTL and testbench
==================================

# seq_chunk_adder

Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per clock, reusing one CHUNK-bit ripple-carry slice and a registered inter-chunk carry. It trades latency for area in datapaths too wide for a single-cycle ripple chain, and adds subtract mode, signed-overflow detection and valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK (elaboration-time check, `$fatal` otherwise)
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- num1_in  in  WIDTH  operand A
- num2_in  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub_in  in  1  0 = A+B+cin, 1 = A−B−cin
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- sum_out  out  WIDTH  result
- carry_out  out  1  add: carry; sub: NOT borrow
- overflow_out  out  1  two's-complement signed overflow

## Operation
- N = WIDTH/CHUNK. States: IDLE, CALC, DONE.
- IDLE: in_ready=1. When in_valid=1, the operands are accepted:
  - latch A and B_eff, where B_eff = sub_in ? ~num2_in : num2_in
  - carry register ← sub_in ? ~cin : cin
  - chunk index ← 0; go to CALC.
- CALC: in_ready=0. Each cycle, chunk i adds A[i*CHUNK +: CHUNK] + B_eff[same] + carry_reg.
  - Write the CHUNK-bit sum into the result register.
  - carry_reg ← chunk carry; i ← i+1.
  - After chunk N−1, go to DONE.
- DONE: out_valid=1; sum_out, carry_out and overflow_out are held stable.
  - carry_out = final carry.
  - overflow_out = (A[W−1] == B_eff[W−1]) && (sum[W−1] != A[W−1]).
  - On out_ready=1, go to IDLE. No new operand is accepted in the same cycle.
- Inputs are ignored outside an accepting IDLE cycle; changes to num*_in, cin and sub_in during CALC/DONE have no effect.
- Wrap-around: sum is modulo 2^WIDTH; carry_out carries the lost bit.
- CHUNK == WIDTH: N=1, so the block degenerates to a one-cycle registered adder.

## Timing
- Reset values (next edge with rst=1):
  - state=IDLE, in_ready=1
  - out_valid=0, sum_out=0, carry_out=0, overflow_out=0
  - all internal registers 0.
- Accept at edge t: CALC during cycles t+1..t+N. out_valid rises after edge t+N.
  - Latency is N cycles from acceptance to out_valid.
- Result stays valid for one or more cycles until out_ready. in_ready returns to 1 the cycle after the out_ready handshake.
  - Minimum initiation interval is N+2 cycles.
- rst during CALC or DONE: the operation is aborted, the result is discarded, and reset values appear the next cycle. rst has priority over every handshake.
- in_valid and out_ready may both be high in DONE: only the output handshake completes.
- in_ready and out_valid are never both 1.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package adder_pkg:
  - state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
  - function for the chunk-index width, clog2(N), minimum 1.
- One sub-module: the existing rca_nbit, instantiated once with n=CHUNK as the per-chunk slice.
- The FSM, operand/result shift registers and carry register live in the top module.

## Test plan
(WIDTH=16, CHUNK=4 unless noted)
- Reset → in_ready=1, out_valid=0, sum_out=0, carry_out=0, overflow_out=0.
- Add 0x0000+0x0000, cin=0 → after 4 cycles sum=0x0000, carry=0, ovf=0.
- Add 0xFFFF+0xFFFF, cin=1 → sum=0xFFFF, carry=1, ovf=0.
- Add 0x7FFF+0x0001, cin=0 → sum=0x8000, carry=0, ovf=1.
- Sub 0x0005−0x0007, cin=0 → sum=0xFFFE, carry=0 (borrow).
  - Then 0x8000−0x0001 → sum=0x7FFF, carry=1, ovf=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → result stable; a new in_valid is ignored until the handshake completes.
  - Assert rst at CALC cycle 2 → IDLE next cycle and no out_valid.
  - Repeat with CHUNK=16 (latency 1) and CHUNK=1 (latency 16).

Source files
------------

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the sequential chunked adder:
//   state_t   - controller state encoding (IDLE / CALC / DONE)
//   idx_width - width of the chunk-index counter for N chunks (minimum 1 bit)
// ---------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a 1-bit counter so that the
    // index register has a legal, non-zero width.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rca_nbit.sv
// ---------------------------------------------------------------------------
// rca_nbit
// Purely combinational n-bit ripple-carry adder: s = a + b + cin.
// Ports:
//   a, b  in  [n-1:0]  addends
//   cin   in           carry into bit 0
//   s     out [n-1:0]  sum
//   cout  out          carry out of bit n-1
// ---------------------------------------------------------------------------
module rca_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[n];

endmodule

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
// Multi-cycle WIDTH-bit adder/subtractor that reuses one CHUNK-bit ripple
// slice, processing the operands least-significant chunk first and carrying
// between chunks through a register. Result appears N = WIDTH/CHUNK cycles
// after acceptance and is held until the consumer takes it.
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   in_valid      in   operands presented
//   in_ready      out  block idle and able to accept operands
//   num1_in       in   [WIDTH-1:0] operand A
//   num2_in       in   [WIDTH-1:0] operand B
//   cin           in   carry-in (add) / borrow-in (sub)
//   sub_in        in   0: A+B+cin, 1: A-B-cin
//   out_valid     out  result valid and held stable
//   out_ready     in   consumer accepts result
//   sum_out       out  [WIDTH-1:0] result modulo 2^WIDTH
//   carry_out     out  add: carry out; sub: NOT borrow
//   overflow_out  out  two's-complement signed overflow
// ---------------------------------------------------------------------------
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1_in,
    input  logic [WIDTH-1:0] num2_in,
    input  logic             cin,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $fatal(1, "seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t state, state_next;

    // Operands shift right by one chunk per CALC cycle so the slice always
    // reads the low chunk; the result fills from the top and shifts down.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry_reg;
    logic             ovf_reg;
    // Operand sign bits are shifted out of a_reg/b_reg before the last chunk
    // completes, so they are captured separately for the overflow test.
    logic             a_msb;
    logic             b_msb;
    logic [IDX_W-1:0] idx;

    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic             last_chunk;

    assign last_chunk = (idx == LAST_IDX);

    rca_nbit #(
        .n (CHUNK)
    ) u_slice (
        .a    (a_reg[CHUNK-1:0]),
        .b    (b_reg[CHUNK-1:0]),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_co)
    );

    if (N == 1) begin : g_single_chunk
        assign sum_shifted = slice_s;
    end else begin : g_multi_chunk
        assign sum_shifted = {slice_s, sum_reg[WIDTH-1:CHUNK]};
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment first guarantees state_next is written on
    // every path, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)   state_next = CALC;
            CALC:    if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is cleared by reset so the held outputs
    // read zero after reset, not stale data from an aborted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~borrow in two's complement.
                        a_reg     <= num1_in;
                        b_reg     <= sub_in ? ~num2_in : num2_in;
                        carry_reg <= sub_in ? ~cin : cin;
                        a_msb     <= num1_in[WIDTH-1];
                        b_msb     <= sub_in ? ~num2_in[WIDTH-1] : num2_in[WIDTH-1];
                        idx       <= '0;
                    end
                end
                CALC: begin
                    a_reg     <= a_reg >> CHUNK;
                    b_reg     <= b_reg >> CHUNK;
                    sum_reg   <= sum_shifted;
                    carry_reg <= slice_co;
                    idx       <= idx + 1'b1;
                    if (last_chunk) begin
                        ovf_reg <= (a_msb == b_msb) && (slice_s[CHUNK-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign sum_out      = sum_reg;
    assign carry_out    = carry_reg;
    assign overflow_out = ovf_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
// Three instances (CHUNK = 4, 16, 1; WIDTH = 16) share one stimulus stream.
// A cycle-level reference model predicts ready/valid timing and the
// arithmetic result from plain integer arithmetic; a negedge process compares
// every instance against it, and directed vectors pin literal results.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

    localparam int W  = 16;
    localparam int NI = 3;
    localparam int LAT [NI] = '{4, 1, 16};

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         cin;
    logic         sub;

    logic         in_ready_o  [NI];
    logic         out_valid_o [NI];
    logic [W-1:0] sum_o       [NI];
    logic         carry_o     [NI];
    logic         ovf_o       [NI];

    int n_cmp;
    int n_fail;

    // Model: 0 = idle, 1 = busy, 2 = result held
    int   phase [NI];
    int   cnt   [NI];
    res_t exp_res;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .num1_in(num1), .num2_in(num2), .cin(cin), .sub_in(sub),
        .out_valid(out_valid_o[0]), .out_ready(out_ready), .sum_out(sum_o[0]),
        .carry_out(carry_o[0]), .overflow_out(ovf_o[0])
    );

    seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .num1_in(num1), .num2_in(num2), .cin(cin), .sub_in(sub),
        .out_valid(out_valid_o[1]), .out_ready(out_ready), .sum_out(sum_o[1]),
        .carry_out(carry_o[1]), .overflow_out(ovf_o[1])
    );

    seq_chunk_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[2]),
        .num1_in(num1), .num2_in(num2), .cin(cin), .sub_in(sub),
        .out_valid(out_valid_o[2]), .out_ready(out_ready), .sum_out(sum_o[2]),
        .carry_out(carry_o[2]), .overflow_out(ovf_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Integer-arithmetic reference: unsigned result for sum/carry, signed
    // result range for overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        res_t   r;
        longint ua, ub, uc, full, sa, sb, sres;
        ua = longint'(a);
        ub = longint'(b);
        uc = longint'(c);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!s) begin
            full = ua + ub + uc;
            r.co = (full >= 65536);
            sres = sa + sb + uc;
        end else begin
            full = ua - ub - uc;
            r.co = (full >= 0);
            sres = sa - sb - uc;
        end
        r.sum = full[W-1:0];
        r.ov  = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                phase[k] <= 0;
                cnt[k]   <= 0;
            end else begin
                case (phase[k])
                    0: if (in_valid) begin
                        phase[k] <= 1;
                        cnt[k]   <= LAT[k];
                    end
                    1: begin
                        cnt[k] <= cnt[k] - 1;
                        if (cnt[k] == 1) phase[k] <= 2;
                    end
                    default: if (out_ready) phase[k] <= 0;
                endcase
            end
        end
        if (!rst && in_valid && phase[0] == 0) exp_res <= model(num1, num2, cin, sub);
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("u%0d in_ready", k), 32'(in_ready_o[k]), 32'(phase[k] == 0));
                check($sformatf("u%0d out_valid", k), 32'(out_valid_o[k]), 32'(phase[k] == 2));
                if (phase[k] == 2) begin
                    check($sformatf("u%0d sum", k), 32'(sum_o[k]), 32'(exp_res.sum));
                    check($sformatf("u%0d carry", k), 32'(carry_o[k]), 32'(exp_res.co));
                    check($sformatf("u%0d ovf", k), 32'(ovf_o[k]), 32'(exp_res.ov));
                end
            end
        end
    end

    // Called #2 after an edge with all instances idle; returns #2 after the
    // accepting edge with operands scrambled to show they are ignored.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s);
        num1 = a; num2 = b; cin = c; sub = s; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        num1 = 16'($urandom); num2 = 16'($urandom);
        cin  = 1'($urandom);  sub  = 1'($urandom);
    endtask

    task automatic wait_all_valid();
        int i;
        i = 0;
        while (!(out_valid_o[0] && out_valid_o[1] && out_valid_o[2]) && i < 100) begin
            @(posedge clk); #2;
            i++;
        end
        check("wait all valid", {29'd0, out_valid_o[2], out_valid_o[1], out_valid_o[0]}, 32'd7);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] lsum,
                                input logic lco, input logic lov);
        check({tag, " model sum"}, 32'(exp_res.sum), 32'(lsum));
        check({tag, " model carry"}, 32'(exp_res.co), 32'(lco));
        check({tag, " model ovf"}, 32'(exp_res.ov), 32'(lov));
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s u%0d sum lit", tag, k), 32'(sum_o[k]), 32'(lsum));
            check($sformatf("%s u%0d carry lit", tag, k), 32'(carry_o[k]), 32'(lco));
            check($sformatf("%s u%0d ovf lit", tag, k), 32'(ovf_o[k]), 32'(lov));
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic [W-1:0] lsum,
                         input logic lco, input logic lov);
        int lat;
        start_op(a, b, c, s);
        lat = 0;
        while (!out_valid_o[0] && lat < 50) begin
            @(posedge clk); #2;
            lat++;
        end
        check({tag, " latency u0"}, 32'(lat), 32'd4);
        wait_all_valid();
        check_result(tag, lsum, lco, lov);
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s u%0d in_ready", tag, k), 32'(in_ready_o[k]), 32'd1);
            check($sformatf("%s u%0d out_valid", tag, k), 32'(out_valid_o[k]), 32'd0);
            check($sformatf("%s u%0d sum", tag, k), 32'(sum_o[k]), 32'd0);
            check($sformatf("%s u%0d carry", tag, k), 32'(carry_o[k]), 32'd0);
            check($sformatf("%s u%0d ovf", tag, k), 32'(ovf_o[k]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        num1 = '0; num2 = '0; cin = 1'b0; sub = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check_reset_values("reset");
        rst = 1'b0;

        do_op("add0",    16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        do_op("addffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        do_op("addovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("addmix",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        do_op("subneg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("subovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("subbin",  16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0);

        // Backpressure: result held for 5 cycles while a new request is
        // offered, then both handshakes high together.
        start_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        wait_all_valid();
        num1 = 16'h1111; num2 = 16'h2222; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #2;
        end
        check_result("hold", 16'h0000, 1'b1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("post hs u%0d in_ready", k), 32'(in_ready_o[k]), 32'd1);
            check($sformatf("post hs u%0d out_valid", k), 32'(out_valid_o[k]), 32'd0);
        end
        @(posedge clk); #2;

        // Reset in the second CALC cycle of the CHUNK=4 instance.
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        check_reset_values("abort");
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #2;
        end
        for (int k = 0; k < NI; k++) begin
            check($sformatf("abort idle u%0d out_valid", k), 32'(out_valid_o[k]), 32'd0);
        end

        do_op("recover", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
